// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

   // Operation select driven by the execute-stage control.
   typedef enum logic [1:0] {
      MDU_MULU = 2'b00,
      MDU_MULS = 2'b01,
      MDU_DIVU = 2'b10,
      MDU_DIVS = 2'b11
   } mduOp_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      FINISH = 2'b10
   } mduState_e;

   // Most-negative two's-complement value for a given operand width,
   // returned wide so any WIDTH up to 64 can slice it.
   function automatic logic [63:0] mostNeg(input int unsigned width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Start/busy/done handshake and operand/result bus between control and the unit.
interface mul_div_unit_if #(parameter int WIDTH = 16);
   import mdu_pkg::*;

   logic             start;
   mduOp_e           op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             div_zero;
   logic             ovf;

   modport master (
      output start, op, a, b,
      input  busy, done, result, result_hi, zero, div_zero, ovf
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, result_hi, zero, div_zero, ovf
   );
endinterface

// File: rtl/mdu_datapath.sv
// Shift/accumulate registers for one shift-add multiply or restoring divide
// step per enabled cycle. Works on unsigned magnitudes only.
module mdu_datapath #(parameter int WIDTH = 16) (
   input  logic             clk,
   input  logic             load,
   input  logic             step,
   input  logic             isDiv,
   input  logic [WIDTH-1:0] magA,
   input  logic [WIDTH-1:0] magB,
   output logic [WIDTH-1:0] accHi,
   output logic [WIDTH-1:0] accLo
);
   logic [WIDTH-1:0] hiReg;
   logic [WIDTH-1:0] loReg;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mulAdd;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   shifted;
   logic             geq;
   logic [WIDTH-1:0] subRem;

   // Candidate next values for both a multiply step and a divide step.
   always_comb begin
      mulAdd  = loReg[0] ? mcand : '0;
      mulSum  = {1'b0, hiReg} + {1'b0, mulAdd};
      shifted = {hiReg, loReg[WIDTH-1]};
      geq     = (shifted >= {1'b0, mcand});
      // When geq holds the difference is below the divisor, so it fits WIDTH bits.
      subRem  = shifted[WIDTH-1:0] - mcand;
   end

   // Load operands on acceptance, then advance one iteration per step.
   // NOTE: these working registers carry no reset; they are always loaded
   // before use and the top clears the visible outputs on reset.
   always_ff @(posedge clk) begin
      if (load) begin
         hiReg <= '0;
         loReg <= magA;
         mcand <= magB;
      end else if (step) begin
         if (isDiv) begin
            hiReg <= geq ? subRem : shifted[WIDTH-1:0];
            loReg <= {loReg[WIDTH-2:0], geq};
         end else begin
            hiReg <= mulSum[WIDTH:1];
            loReg <= {mulSum[0], loReg[WIDTH-1:1]};
         end
      end
   end

   assign accHi = hiReg;
   assign accLo = loReg;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MUL/DIV unit beside the ALU: sequencer, counter, sign handling
// and registered results; the arithmetic lives in mdu_datapath.
module mul_div_unit
   import mdu_pkg::*;
#(parameter int WIDTH = 16) (
   input  logic           clk,
   input  logic           reset,
   mul_div_unit_if.slave  bus
);
   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(mostNeg(WIDTH));

   mduState_e        stateReg, stateNext;
   logic [CNT_W-1:0] cntReg;
   logic             load, step;

   logic             reqDiv, reqSigned, aNeg, bNeg, reqDz, reqOvf;
   logic [WIDTH-1:0] magA, magB, accHi, accLo;

   logic             isDivReg, negReg, signAReg, dzReg, ovfReg;
   logic [WIDTH-1:0] aReg;

   logic [2*WIDTH-1:0] prodMag, prodSigned;
   logic [WIDTH-1:0]   resLo, resHi;

   logic             busyReg, doneReg, zeroReg, dzOut, ovfOut;
   logic [WIDTH-1:0] resultReg, resultHiReg;

   // Decode the incoming request: magnitudes and exception cases.
   always_comb begin
      reqDiv    = bus.op[1];
      reqSigned = bus.op[0];
      aNeg      = reqSigned & bus.a[WIDTH-1];
      bNeg      = reqSigned & bus.b[WIDTH-1];
      magA      = aNeg ? -bus.a : bus.a;
      magB      = bNeg ? -bus.b : bus.b;
      reqDz     = reqDiv && (bus.b == '0);
      reqOvf    = (bus.op == MDU_DIVS) && (bus.a == MOST_NEG) && (bus.b == '1);
   end

   // Next-state and datapath controls.
   // NOTE: every output of this block gets a default first so no path
   // leaves one unassigned and infers a latch.
   always_comb begin
      stateNext = stateReg;
      load      = 1'b0;
      step      = 1'b0;
      unique case (stateReg)
         IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               stateNext = (reqDz || reqOvf) ? FINISH : RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cntReg == CNT_W'(1)) stateNext = FINISH;
         end
         FINISH:  stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Sign correction and exception overrides on the finished magnitudes.
   always_comb begin
      prodMag    = {accHi, accLo};
      prodSigned = negReg ? -prodMag : prodMag;
      if (dzReg) begin
         resLo = '1;
         resHi = aReg;
      end else if (ovfReg) begin
         resLo = aReg;
         resHi = '0;
      end else if (isDivReg) begin
         resLo = negReg   ? -accLo : accLo;
         resHi = signAReg ? -accHi : accHi;
      end else begin
         {resHi, resLo} = prodSigned;
      end
   end

   // State, counter, latched request and registered outputs.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg    <= IDLE;
         cntReg      <= '0;
         isDivReg    <= 1'b0;
         negReg      <= 1'b0;
         signAReg    <= 1'b0;
         dzReg       <= 1'b0;
         ovfReg      <= 1'b0;
         aReg        <= '0;
         busyReg     <= 1'b0;
         doneReg     <= 1'b0;
         resultReg   <= '0;
         resultHiReg <= '0;
         zeroReg     <= 1'b0;
         dzOut       <= 1'b0;
         ovfOut      <= 1'b0;
      end else begin
         stateReg <= stateNext;
         busyReg  <= (stateReg == RUN);
         doneReg  <= (stateReg == FINISH);
         if (load) begin
            cntReg   <= CNT_W'(WIDTH);
            isDivReg <= reqDiv;
            negReg   <= aNeg ^ bNeg;
            signAReg <= aNeg;
            dzReg    <= reqDz;
            ovfReg   <= reqOvf;
            aReg     <= bus.a;
         end else if (step) begin
            cntReg <= cntReg - CNT_W'(1);
         end
         if (stateReg == FINISH) begin
            resultReg   <= resLo;
            resultHiReg <= resHi;
            zeroReg     <= ({resHi, resLo} == '0);
            dzOut       <= dzReg;
            ovfOut      <= ovfReg;
         end
      end
   end

   mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk   (clk),
      .load  (load),
      .step  (step),
      .isDiv (isDivReg),
      .magA  (magA),
      .magB  (magB),
      .accHi (accHi),
      .accLo (accLo)
   );

   assign bus.busy      = busyReg;
   assign bus.done      = doneReg;
   assign bus.result    = resultReg;
   assign bus.result_hi = resultHiReg;
   assign bus.zero      = zeroReg;
   assign bus.div_zero  = dzOut;
   assign bus.ovf       = ovfOut;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parameterised iterative multiply/divide unit that extends the single-cycle ALU with MUL/DIV-class operations. It sits beside the ALU in the execute stage. It takes operands from the register file read ports and returns a WIDTH-bit low result plus a WIDTH-bit high result (product high half or remainder). It runs a start/busy/done handshake so the control FSM can stall while it computes.

Parameters:
WIDTH, 16, operand and result width in bits; must be at least 4.
CNT_W, $clog2(WIDTH+1), width of the internal iteration counter; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse when result, result_hi and flags update
result  output  WIDTH  product low half / quotient
result_hi  output  WIDTH  product high half / remainder
zero  output  1  full 2*WIDTH result (result_hi,result) == 0
div_zero  output  1  divide with b==0
ovf  output  1  DIVS with a = most-negative value and b = -1

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs): state IDLE; busy, done, result, result_hi, zero, div_zero and ovf all 0; counter 0.
- States and transitions:
  - IDLE: start=1 latches a, b, op and operand signs, then goes to RUN.
  - Exception path: if op is a divide and b==0, or the DIVS overflow case applies, go to FINISH instead of RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, WIDTH cycles, counter WIDTH down to 1. Then go to FINISH.
  - FINISH: apply sign correction, register outputs, done=1 for this cycle only, return to IDLE.
- Latency: start sampled at edge E0; done and new outputs visible after edge E(WIDTH+1); busy high after edges E1..E(WIDTH).
- Exception latency: done after E1; busy never rises.
- Signed operations: iterate on magnitudes.
  - MULS: negate the 2*WIDTH product if the operand signs differ.
  - DIVS: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: result = all ones, result_hi = a, div_zero=1, ovf=0.
- DIVS overflow (a = 100..0, b = all ones): result = a, result_hi = 0, ovf=1, div_zero=0.
- div_zero and ovf are 0 for every multiply; all flags update only on done.
- start while busy=1 or during FINISH: ignored, not queued. start in the same cycle done is high is accepted, because FINISH returns to IDLE first and IDLE samples start.
- Outputs hold their last values between operations. Operand inputs may change freely after acceptance.
- Reset mid-operation: abort, clear outputs, no done pulse.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULU/MULS/DIVU/DIVS;
  - state encodings IDLE/RUN/FINISH;
  - helper constant for the most-negative value of WIDTH.
- One sub-module, mdu_datapath: holds the shift/accumulate registers and the add/subtract step, driven by a step enable.
- The FSM and counter stay in mul_div_unit.

Test Plan:
- MULU a=300, b=300 (WIDTH=16) -> done after exactly 17 cycles; result_hi=0x0001, result=0x5F90; zero=0; busy high for 16 cycles.
- MULS a=0xFFFD (-3), b=5 -> result_hi=0xFFFF, result=0xFFF1; then MULU a=0, b=0x1234 -> zero=1.
- DIVU a=1000, b=7 -> result=0x008E, result_hi=0x0006. DIVS a=0xFFF9 (-7), b=2 -> result=0xFFFD, result_hi=0xFFFF.
- Exceptions:
  - DIVU a=0x1234, b=0 -> done after 1 cycle; result=0xFFFF, result_hi=0x1234, div_zero=1; busy stays 0.
  - DIVS a=0x8000, b=0xFFFF -> ovf=1, result=0x8000.
- Handshake:
  - Pulse start again at cycle 5 of a running MULU -> ignored; single done, original result.
  - start held high across done -> back-to-back operations with no idle gap.
- Reset at cycle 8 of a DIVU -> next cycle busy=0, all outputs 0, no done; a new start afterwards completes correctly.
